// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl_pkg
//  Description : Shared encodings for the multiply/divide sequencer:
//                operation codes, FSM states and op-decoding helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // Operation encodings as presented on the op port
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Divide ops have op[1] set
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have op[0] clear
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the mul/div datapath.
//                Multiply: shift-add, {acc,mq} holds the growing product and
//                mq[0] is the current multiplier bit.
//                Divide: restoring, acc is the partial remainder and mq
//                shifts the dividend out (MSB first) and the quotient in.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mq
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Compute both candidate updates and select by op class
    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_mq[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
        w_shift = {i_acc, i_mq[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_b};
        o_acc   = i_acc;
        o_mq    = i_mq;
        if (op_is_div(i_op)) begin
            // Top bit clear means the trial subtraction did not go negative
            if (!w_diff[WIDTH]) begin
                o_acc = w_diff[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = w_shift[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add shifts into the accumulator MSB
            o_acc = w_sum[WIDTH:1];
            o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                IDLE -> RUN (WIDTH iterations) -> FIX (sign fix, HI/LO
//                write) -> IDLE with a one-cycle done pulse. Stalls the
//                pipeline when a HI/LO consumer or new op meets a busy unit.
//                Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV;
//                without it MULT/DIV behave as MULTU/DIVU.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             hi_rd,
    input  logic             lo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;

    logic               w_sgn_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_mq;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic               w_last;

`ifdef MULDIV_SIGNED_EN
    assign w_sgn_op = op_is_signed(op);
`else
    assign w_sgn_op = 1'b0;
`endif

    // Operand magnitudes; sign flags are zero for unsigned ops
    assign w_sa    = w_sgn_op & rs_data[WIDTH-1];
    assign w_sb    = w_sgn_op & rt_data[WIDTH-1];
    assign w_a_mag = w_sa ? (-rs_data) : rs_data;
    assign w_b_mag = w_sb ? (-rt_data) : rt_data;

    assign w_last  = (r_cnt == CNT_W'(WIDTH-1));
    assign busy    = (r_state != ST_IDLE);
    assign stall   = busy & (start | hi_rd | lo_rd | mthi | mtlo);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign done    = r_done;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op  (r_op),
        .i_acc (r_acc),
        .i_mq  (r_mq),
        .i_b   (r_b),
        .o_acc (w_step_acc),
        .o_mq  (w_step_mq)
    );

    // Final HI/LO values including sign correction and divide-by-zero result
    always_comb begin
        w_prod     = {r_acc, r_mq};
        w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
        w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fix   = w_prod_fix[WIDTH-1:0];
        if (op_is_div(r_op)) begin
            if (r_b == '0) begin
                w_hi_fix = r_a_orig;
                w_lo_fix = '1;
            end else begin
                w_hi_fix = r_neg_r ? (-r_acc) : r_acc;
                w_lo_fix = r_neg_q ? (-r_mq)  : r_mq;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush aborts from any state and beats start
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start)  w_state_nxt = ST_RUN;
                ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
                ST_FIX:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath, counter, HI/LO and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_acc    <= '0;
            r_mq     <= '0;
            r_b      <= '0;
            r_a_orig <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_op     <= op;
                            r_acc    <= '0;
                            r_mq     <= w_a_mag;
                            r_b      <= w_b_mag;
                            r_a_orig <= rs_data;
                            r_neg_q  <= w_sa ^ w_sb;
                            r_neg_r  <= w_sa;
                            r_cnt    <= '0;
                        end else begin
                            if (mthi) r_hi <= rs_data;
                            if (mtlo) r_lo <= rs_data;
                        end
                    end
                    ST_RUN: begin
                        r_acc <= w_step_acc;
                        r_mq  <= w_step_mq;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    ST_FIX: begin
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Self-checking bench for muldiv_ctrl. Expected HI/LO pairs
//                are computed by a behavioural model when an op is issued,
//                queued, and compared when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        hi_rd = 1'b0;
    logic        lo_rd = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi_rd   (hi_rd),
        .lo_rd   (lo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic               sgn;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] p;
        logic signed [31:0] q;
        logic signed [31:0] r;
`ifdef MULDIV_SIGNED_EN
        sgn = (o == OP_MULT) || (o == OP_DIV);
`else
        sgn = 1'b0;
`endif
        if (!o[1]) begin
            if (sgn) begin
                sa  = {{32{a[31]}}, a};
                sbv = {{32{b[31]}}, b};
                p   = sa * sbv;
                return p;
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Issue one op and follow it to completion; optionally hold MFLO in EX
    // throughout, or pulse MTLO on cycle mt_cycle while busy
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic hold_lo, input int mt_cycle);
        int          cyc;
        int          busy_cyc;
        int          stall_bad;
        logic [63:0] exp;
        sb_q.push_back(model(o, a, b));
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        lo_rd   = hold_lo;
        tick;
        start   = 1'b0;
        rs_data = 32'h0;
        rt_data = 32'h0;
        cyc = 0; busy_cyc = 0; stall_bad = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            if (hold_lo && (stall !== busy)) stall_bad++;
            if (mt_cycle == cyc) begin
                mtlo    = 1'b1;
                rs_data = 32'hDEAD_BEEF;
                #1;
                check_eq("stall_on_mtlo", {63'h0, stall}, 64'h1);
            end
            tick;
            mtlo = 1'b0;
            cyc++;
        end
        if (!done) begin
            check_eq("done_timeout", 64'h0, 64'h1);
        end else begin
            check_eq("latency", 64'(cyc), 64'd33);
            check_eq("busy_cycles", 64'(busy_cyc), 64'd33);
            if (hold_lo) begin
                check_eq("stall_while_busy", 64'(stall_bad), 64'd0);
                check_eq("stall_at_done", {63'h0, stall}, 64'h0);
            end
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 64'h0, 64'h1);
            end else begin
                exp = sb_q.pop_front();
                check_eq("hilo", {hi, lo}, exp);
            end
        end
        lo_rd = 1'b0;
        tick;
        check_eq("done_pulse", {63'h0, done}, 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lo_before;
        int          done_seen;
        // Reset state
        #12;
        check_eq("rst_hi", {32'h0, hi}, 64'h0);
        check_eq("rst_lo", {32'h0, lo}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_stall", {63'h0, stall}, 64'h0);
        check_eq("rst_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        tick;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        check_eq("multu_ff_lit", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, -1);
        check_eq("divu_100_7_lit", {hi, lo}, {32'd2, 32'd14});
        run_op(OP_DIVU, 32'h1234, 32'h0, 1'b0, -1);
        check_eq("divu_by0_lit", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, -1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, -1);
        run_op(OP_MULTU, 32'd7, 32'd9, 1'b0, 5);

        // MTHI in IDLE, then a flushed MULTU leaves HI/LO untouched
        mthi    = 1'b1;
        rs_data = 32'hA5A5_A5A5;
        tick;
        mthi    = 1'b0;
        check_eq("mthi_write", {32'h0, hi}, {32'h0, 32'hA5A5_A5A5});
        lo_before = lo;
        op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_eq("flush_busy", {63'h0, busy}, 64'h0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick;
        end
        check_eq("flush_no_done", 64'(done_seen), 64'd0);
        check_eq("flush_hilo", {hi, lo}, {32'hA5A5_A5A5, lo_before});
        hi_rd = 1'b1;
        #1;
        check_eq("mfhi_idle_stall", {63'h0, stall}, 64'h0);
        hi_rd = 1'b0;

        // Asynchronous reset in the middle of a divide
        op = OP_DIVU; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hilo", {hi, lo}, 64'h0);
        check_eq("arst_busy", {63'h0, busy}, 64'h0);
        #1;
        rst_n = 1'b1;
        tick;
        run_op(OP_DIVU, 32'd1000, 32'd3, 1'b0, -1);

        // Random mix
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            run_op(ro, ra, rb, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
